load_store_unit: RTL and testbench

Data-memory access unit of the RISC-V softcore: executes the loads and stores flagged by the control decoder (`mem_to_reg`/`mem_write`) against a single-port request/grant data bus. Aligns store data into byte lanes, extracts and sign/zero-extends load data, and flags misaligned or illegal accesses. Sits in the MEM stage and stalls the pipeline while a bus transaction is in flight.

---
 rtl/riscv_pkg.sv | 70 +++++++
 rtl/lsu_load_align.sv | 32 +++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared opcode/funct3 constants, LSU state encoding and
//               load/store legality and lane helpers for the softcore.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;
    localparam logic [1:0] c_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_REQ    = 2'd1,
        LSU_WAIT_R = 2'd2,
        LSU_DONE   = 2'd3
    } lsu_state_e;

    // Size code 11 never exists; unsigned store variants are rejected too.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic ok;
        case (funct3[1:0])
            c_SIZE_B: ok = 1'b1;
            c_SIZE_H: ok = ~offset[0];
            c_SIZE_W: ok = (offset == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok & ~(is_store & funct3[2]);
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            c_SIZE_B: be = 4'b0001 << offset;
            c_SIZE_H: be = 4'b0011 << offset;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            c_SIZE_B: d = {4{wdata[7:0]}};
            c_SIZE_H: d = {2{wdata[15:0]}};
            default:  d = wdata;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Selects the addressed byte/halfword of a read word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] value_o
);

    logic [31:0] w_shifted;
    logic        w_signed;

    always_comb begin
        w_shifted = word_i >> {offset_i, 3'b000};
        w_signed  = ~funct3_i[2];
        value_o   = word_i;
        case (funct3_i[1:0])
            c_SIZE_B: value_o = {{24{w_signed & w_shifted[7]}},  w_shifted[7:0]};
            c_SIZE_H: value_o = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            default:  value_o = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store unit driving a single-port req/gnt data
//               bus, with lane alignment, load extension and access checks.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  offset_q, offset_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        misaligned_q, misaligned_d;

    logic        w_access;
    logic        w_is_store;
    logic        w_legal;
    logic [31:0] w_load_value;

    assign w_access   = mem_read_i | mem_write_i;
    assign w_is_store = mem_write_i;
    assign w_legal    = access_legal(w_is_store, funct3_i, addr_i[1:0]);

    lsu_load_align u_load_align (
        .word_i   (bus_rdata_i),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .value_o  (w_load_value)
    );

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        funct3_d      = funct3_q;
        store_d       = store_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misaligned_d  = 1'b0;
        stall_o       = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (w_access) begin
                    if (w_legal) begin
                        stall_o     = 1'b1;
                        offset_d    = addr_i[1:0];
                        funct3_d    = funct3_i;
                        store_d     = w_is_store;
                        bus_req_d   = 1'b1;
                        bus_we_d    = w_is_store;
                        bus_addr_d  = {addr_i[31:2], 2'b00};
                        bus_wdata_d = store_data(funct3_i[1:0], wdata_i);
                        bus_be_d    = w_is_store ? store_be(funct3_i[1:0], addr_i[1:0]) : 4'b0000;
                        state_d     = LSU_REQ;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            LSU_REQ: begin
                stall_o = 1'b1;
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    state_d   = store_q ? LSU_DONE : LSU_WAIT_R;
                end
            end
            LSU_WAIT_R: begin
                stall_o = 1'b1;
                if (bus_rvalid_i) begin
                    rdata_d       = w_load_value;
                    rdata_valid_d = 1'b1;
                    state_d       = LSU_DONE;
                end
            end
            // Inputs are still the completed instruction here; never re-sample them.
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= LSU_IDLE;
            offset_q      <= 2'b00;
            funct3_q      <= 3'b000;
            store_q       <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'h0;
            bus_wdata_q   <= 32'h0;
            bus_be_q      <= 4'b0000;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            funct3_q      <= funct3_d;
            store_q       <= store_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign misaligned_o  = misaligned_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign bus_be_o      = bus_be_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: per-cycle expected
//               timeline from a transaction-level model, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, misaligned_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misaligned_o  (misaligned_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_be_o      (bus_be_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    // Expected timeline, indexed by cycle number.
    bit          exp_stall [MAXC];
    bit          exp_req   [MAXC];
    bit          exp_mis   [MAXC];
    bit          exp_rv    [MAXC];
    bit          exp_upd   [MAXC];
    logic [31:0] exp_val   [MAXC];

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;

    int          stall_cnt = 0, mis_cnt = 0, rv_cnt = 0, req_cnt = 0;
    logic [31:0] cap_addr = 0, cap_wdata = 0, cap_rdata = 0;
    logic [3:0]  cap_be = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (exp_upd[cyc]) m_rdata = exp_val[cyc];
            if (chk_en) begin
                chk("stall_o",       32'(stall_o),       32'(exp_stall[cyc]));
                chk("bus_req_o",     32'(bus_req_o),     32'(exp_req[cyc]));
                chk("misaligned_o",  32'(misaligned_o),  32'(exp_mis[cyc]));
                chk("rdata_valid_o", 32'(rdata_valid_o), 32'(exp_rv[cyc]));
                chk("rdata_o",       rdata_o,            m_rdata);
                if (exp_req[cyc]) begin
                    chk("bus_we_o",   32'(bus_we_o), 32'(cur_we));
                    chk("bus_addr_o", bus_addr_o,    cur_addr);
                    chk("bus_be_o",   32'(bus_be_o), 32'(cur_be));
                    if (cur_we) chk("bus_wdata_o", bus_wdata_o, cur_wdata);
                end
            end
        end
        if (stall_o) stall_cnt++;
        if (misaligned_o) mis_cnt++;
        if (bus_req_o) begin
            req_cnt++;
            cap_addr  = bus_addr_o;
            cap_wdata = bus_wdata_o;
            cap_be    = bus_be_o;
        end
        if (rdata_valid_o) begin
            rv_cnt++;
            cap_rdata = rdata_o;
        end
    end

    function automatic logic [31:0] load_model(input logic [31:0] word, input int off,
                                               input logic [2:0] f3);
        longint w;
        longint v;
        w = longint'(word);
        case (f3[1:0])
            2'b00: begin
                v = (w >> (8 * off)) & 255;
                if (!f3[2] && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = (w >> (8 * off)) & 65535;
                if (!f3[2] && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            mem_read_i   = 1'b0;
            mem_write_i  = 1'b0;
            funct3_i     = 3'($urandom_range(0, 7));
            addr_i       = $urandom;
            wdata_i      = $urandom;
            bus_gnt_i    = 1'($urandom_range(0, 1));
            bus_rvalid_i = 1'($urandom_range(0, 1));
            bus_rdata_i  = $urandom;
            step();
        end
    endtask

    // One instruction; gd = extra grant-wait cycles, rdl = extra rvalid-wait cycles.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input int rdl, input logic [31:0] word);
        int t0, sz, off, nb, d;
        bit st, legal;
        t0    = cyc;
        st    = wr;
        sz    = int'(f3[1:0]);
        off   = int'(a[1:0]);
        legal = (sz != 3) && !(sz == 1 && (off % 2) != 0) && !(sz == 2 && off != 0)
                && !(st && f3[2]);
        mem_read_i   = rd;
        mem_write_i  = wr;
        funct3_i     = f3;
        addr_i       = a;
        wdata_i      = wd;
        bus_gnt_i    = 1'($urandom_range(0, 1));
        bus_rvalid_i = 1'($urandom_range(0, 1));
        bus_rdata_i  = $urandom;
        if (!legal) begin
            if (t0 + 1 < MAXC) exp_mis[t0 + 1] = 1'b1;
            step();
            return;
        end
        d = t0 + 3 + gd + (st ? -1 : rdl);
        if (d < MAXC) begin
            exp_stall[t0] = 1'b1;
            for (int i = 0; i <= gd; i++) begin
                exp_stall[t0 + 1 + i] = 1'b1;
                exp_req[t0 + 1 + i]   = 1'b1;
            end
            if (!st) begin
                for (int j = 0; j <= rdl; j++) exp_stall[t0 + 2 + gd + j] = 1'b1;
                exp_rv[d]  = 1'b1;
                exp_upd[d] = 1'b1;
                exp_val[d] = load_model(word, off, f3);
            end
        end
        cur_we   = st;
        cur_addr = a - 32'(off);
        if (st) begin
            nb        = 1 << sz;
            cur_be    = 4'(((1 << nb) - 1) << off);
            cur_wdata = (sz == 0) ? (wd & 32'hFF) * 32'h01010101 :
                        (sz == 1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        end else begin
            cur_be    = 4'b0000;
            cur_wdata = 32'h0;
        end
        step();
        for (int i = 0; i <= gd; i++) begin
            bus_gnt_i    = (i == gd);
            bus_rvalid_i = 1'($urandom_range(0, 1));
            step();
        end
        if (!st) begin
            for (int j = 0; j <= rdl; j++) begin
                bus_gnt_i    = 1'($urandom_range(0, 1));
                bus_rvalid_i = (j == rdl);
                bus_rdata_i  = (j == rdl) ? word : $urandom;
                step();
            end
        end
        bus_gnt_i    = 1'($urandom_range(0, 1));
        bus_rvalid_i = 1'($urandom_range(0, 1));
        bus_rdata_i  = $urandom;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, m0, q0, kind, c;
        rst = 1'b1;
        mem_read_i = 0; mem_write_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        #3;
        chk("reset stall_o", 32'(stall_o), 32'h0);
        chk("reset bus_req_o", 32'(bus_req_o), 32'h0);
        chk("reset rdata_o", rdata_o, 32'h0);
        chk("reset bus_addr_o", bus_addr_o, 32'h0);
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // SW 0xDEADBEEF to 0x100, immediate grant
        s0 = stall_cnt;
        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        chk("SW stall cycles", 32'(stall_cnt - s0), 32'd2);
        chk("SW bus_addr", cap_addr, 32'h100);
        chk("SW bus_be", 32'(cap_be), 32'hF);
        chk("SW bus_wdata", cap_wdata, 32'hDEADBEEF);

        // SB 0xA5 to 0x203
        access(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0);
        chk("SB bus_addr", cap_addr, 32'h200);
        chk("SB bus_be", 32'(cap_be), 32'h8);
        chk("SB bus_wdata", cap_wdata, 32'hA5A5A5A5);

        // LB / LBU at 0x101 from word 0x00008000
        s0 = stall_cnt; r0 = rv_cnt;
        access(1, 0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h00008000);
        chk("LB rdata", cap_rdata, 32'hFFFFFF80);
        chk("LB rdata_valid pulses", 32'(rv_cnt - r0), 32'd1);
        chk("LB stall cycles", 32'(stall_cnt - s0), 32'd3);
        access(1, 0, 3'b100, 32'h101, 32'h0, 0, 0, 32'h00008000);
        chk("LBU rdata", cap_rdata, 32'h00000080);

        // Misaligned halfword, misaligned word, reserved size 11
        s0 = stall_cnt; m0 = mis_cnt; q0 = req_cnt;
        access(1, 0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0);
        idle(1);
        access(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0);
        idle(1);
        access(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        idle(1);
        chk("illegal misaligned pulses", 32'(mis_cnt - m0), 32'd3);
        chk("illegal bus requests", 32'(req_cnt - q0), 32'd0);
        chk("illegal stall cycles", 32'(stall_cnt - s0), 32'd0);

        // LW with 3 extra grant-wait cycles and rvalid two cycles after grant
        s0 = stall_cnt;
        access(1, 0, 3'b010, 32'h300, 32'h0, 3, 1, 32'h12345678);
        chk("LW delayed stall cycles", 32'(stall_cnt - s0), 32'd7);
        chk("LW delayed rdata", cap_rdata, 32'h12345678);
        idle(1);

        // Reset while waiting for read data
        chk_en = 1'b0;
        r0 = rv_cnt;
        mem_read_i = 1; mem_write_i = 0; funct3_i = 3'b010; addr_i = 32'h400;
        bus_gnt_i = 1; bus_rvalid_i = 0;
        step();
        step();
        bus_gnt_i = 0;
        #1;
        rst = 1'b1;
        mem_read_i = 0;
        #1;
        chk("abort stall_o", 32'(stall_o), 32'h0);
        chk("abort bus_req_o", 32'(bus_req_o), 32'h0);
        chk("abort rdata_o", rdata_o, 32'h0);
        chk("abort bus_be_o", 32'(bus_be_o), 32'h0);
        chk("abort bus_addr_o", bus_addr_o, 32'h0);
        step();
        rst = 1'b0;
        bus_rvalid_i = 1; bus_rdata_i = 32'hFFFFFFFF;
        step();
        bus_rvalid_i = 0;
        step(); step();
        chk("late rvalid pulses", 32'(rv_cnt - r0), 32'd0);
        chk("late rvalid rdata_o", rdata_o, 32'h0);
        c = cyc;
        exp_upd[c] = 1'b1;
        exp_val[c] = 32'h0;
        chk_en = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 7);
            if (kind == 7) idle($urandom_range(1, 2));
            else access(kind <= 2 || kind == 6, kind >= 3, 3'($urandom_range(0, 7)),
                        $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                        $urandom);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
